// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register with flush, bubble insertion and the MADD/MSUB feedback path.
// The hilo_o/cnt_o feedback registers exist only when HILO_ACCUM_EN is defined.
module ex_mem #(
  parameter int ALUOP_W   = 8,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall,
  input  logic                 flush,
  input  logic [ALUOP_W-1:0]   ex_aluop,
  input  logic [31:0]          ex_mem_addr,
  input  logic [31:0]          ex_reg2,
  input  logic [REGADDR_W-1:0] ex_wd,
  input  logic                 ex_wreg,
  input  logic [31:0]          ex_wdata,
  input  logic [31:0]          ex_hi,
  input  logic [31:0]          ex_lo,
  input  logic                 ex_whilo,
  input  logic                 ex_cp0_we,
  input  logic [4:0]           ex_cp0_waddr,
  input  logic [31:0]          ex_cp0_wdata,
  input  logic [31:0]          ex_excepttype,
  input  logic [31:0]          ex_current_inst_address,
  input  logic                 ex_is_in_delayslot,
  input  logic                 ex_isbubble,
  input  logic [63:0]          hilo_i,
  input  logic [1:0]           cnt_i,
  output logic [ALUOP_W-1:0]   mem_aluop,
  output logic [31:0]          mem_mem_addr,
  output logic [31:0]          mem_reg2,
  output logic [REGADDR_W-1:0] mem_wd,
  output logic                 mem_wreg,
  output logic [31:0]          mem_wdata,
  output logic [31:0]          mem_hi,
  output logic [31:0]          mem_lo,
  output logic                 mem_whilo,
  output logic                 mem_cp0_we,
  output logic [4:0]           mem_cp0_waddr,
  output logic [31:0]          mem_cp0_wdata,
  output logic [31:0]          mem_excepttype,
  output logic [31:0]          mem_current_inst_address,
  output logic                 mem_is_in_delayslot,
  output logic                 mem_isbubble,
  output logic [63:0]          hilo_o,
  output logic [1:0]           cnt_o
);
  localparam int W = ALUOP_W + REGADDR_W + 8 * 32 + 5 + 5;
  localparam logic [W-1:0] BUBBLE = {{(W-1){1'b0}}, 1'b1};
  logic [W-1:0] d, q;
  logic bubble;
  logic unused_stall;
  assign bubble = stall[3] & ~stall[4];
  assign unused_stall = ^{stall[5], stall[2:0]};
  // isbubble is the LSB so that flush and bubble load the single-one pattern
  assign d = {ex_aluop, ex_mem_addr, ex_reg2, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo,
              ex_whilo, ex_cp0_we, ex_cp0_waddr, ex_cp0_wdata, ex_excepttype,
              ex_current_inst_address, ex_is_in_delayslot, ex_isbubble};
  assign {mem_aluop, mem_mem_addr, mem_reg2, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo,
          mem_whilo, mem_cp0_we, mem_cp0_waddr, mem_cp0_wdata, mem_excepttype,
          mem_current_inst_address, mem_is_in_delayslot, mem_isbubble} = q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (flush || bubble) q <= BUBBLE;
    else if (!stall[3]) q <= d;
`ifdef HILO_ACCUM_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) {hilo_o, cnt_o} <= '0;
    else if (flush) {hilo_o, cnt_o} <= '0;
    else if (bubble) {hilo_o, cnt_o} <= {hilo_i, cnt_i};
    else if (!stall[3]) {hilo_o, cnt_o} <= '0;
`else
  logic unused_accum;
  assign unused_accum = ^{hilo_i, cnt_i};
  assign hilo_o = '0;
  assign cnt_o  = '0;
`endif
endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: directed self-checking bench for ex_mem; expectations follow HILO_ACCUM_EN.
module tb_ex_mem;
`ifdef HILO_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  logic clk = 0, rst = 1, flush = 0;
  logic [5:0] stall = '0;
  logic [7:0] ex_aluop = '0, mem_aluop;
  logic [31:0] ex_mem_addr = '0, ex_reg2 = '0, ex_wdata = '0, ex_hi = '0, ex_lo = '0;
  logic [31:0] ex_cp0_wdata = '0, ex_excepttype = '0, ex_current_inst_address = '0;
  logic [31:0] mem_mem_addr, mem_reg2, mem_wdata, mem_hi, mem_lo;
  logic [31:0] mem_cp0_wdata, mem_excepttype, mem_current_inst_address;
  logic [4:0] ex_wd = '0, ex_cp0_waddr = '0, mem_wd, mem_cp0_waddr;
  logic ex_wreg = 0, ex_whilo = 0, ex_cp0_we = 0, ex_is_in_delayslot = 0, ex_isbubble = 0;
  logic mem_wreg, mem_whilo, mem_cp0_we, mem_is_in_delayslot, mem_isbubble;
  logic [63:0] hilo_i = '0, hilo_o;
  logic [1:0] cnt_i = '0, cnt_o;
  int total = 0, bad = 0;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .ex_wd(ex_wd),
    .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .ex_cp0_we(ex_cp0_we), .ex_cp0_waddr(ex_cp0_waddr),
    .ex_cp0_wdata(ex_cp0_wdata), .ex_excepttype(ex_excepttype),
    .ex_current_inst_address(ex_current_inst_address),
    .ex_is_in_delayslot(ex_is_in_delayslot), .ex_isbubble(ex_isbubble),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .mem_wd(mem_wd),
    .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_whilo(mem_whilo), .mem_cp0_we(mem_cp0_we), .mem_cp0_waddr(mem_cp0_waddr),
    .mem_cp0_wdata(mem_cp0_wdata), .mem_excepttype(mem_excepttype),
    .mem_current_inst_address(mem_current_inst_address),
    .mem_is_in_delayslot(mem_is_in_delayslot), .mem_isbubble(mem_isbubble),
    .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst) assert (!(stall[4] && !stall[3])) else $error("illegal stall vector %b", stall);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mem_all_or;
    return {32'd0, mem_mem_addr | mem_reg2 | mem_wdata | mem_hi | mem_lo | mem_cp0_wdata |
            mem_excepttype | mem_current_inst_address} |
           {mem_aluop, mem_wd, mem_cp0_waddr, mem_wreg, mem_whilo, mem_cp0_we, mem_is_in_delayslot};
  endfunction

  task automatic load_all;
    ex_aluop = 8'h23; ex_mem_addr = 32'h1000_0040; ex_reg2 = 32'h0BAD_F00D;
    ex_wd = 5'd3; ex_wreg = 1; ex_wdata = 32'hDEAD_BEEF; ex_hi = 32'h1111_2222;
    ex_lo = 32'h3333_4444; ex_whilo = 1; ex_cp0_we = 1; ex_cp0_waddr = 5'd12;
    ex_cp0_wdata = 32'h0000_FF01; ex_excepttype = 32'h0000_0200;
    ex_current_inst_address = 32'hBFC0_0100; ex_is_in_delayslot = 1; ex_isbubble = 0;
  endtask

  initial begin
    step; step;
    rst = 0;
    check("reset_all", mem_all_or(), 64'd0);
    check("reset_isbubble", {63'd0, mem_isbubble}, 64'd0);
    load_all; stall = 6'b000000;
    step;
    check("pass_wd", {59'd0, mem_wd}, 64'd3);
    check("pass_wreg", {63'd0, mem_wreg}, 64'd1);
    check("pass_wdata", {32'd0, mem_wdata}, 64'hDEAD_BEEF);
    check("pass_aluop", {56'd0, mem_aluop}, 64'h23);
    check("pass_addr", {32'd0, mem_mem_addr}, 64'h1000_0040);
    check("pass_pc", {32'd0, mem_current_inst_address}, 64'hBFC0_0100);
    check("pass_cp0", {27'd0, mem_cp0_we, mem_cp0_waddr, mem_cp0_wdata}, {27'd0, 1'b1, 5'd12, 32'h0000_FF01});
    check("pass_isbubble", {63'd0, mem_isbubble}, 64'd0);
    check("pass_cnt", {62'd0, cnt_o}, 64'd0);
    // bubble: MADD first cycle
    stall = 6'b001111; cnt_i = 2'b01; hilo_i = 64'h1_0000_0002;
    step;
    check("bub_wreg", {63'd0, mem_wreg}, 64'd0);
    check("bub_isbubble", {63'd0, mem_isbubble}, 64'd1);
    check("bub_all", mem_all_or(), 64'd0);
    check("bub_cnt", {62'd0, cnt_o}, ACC ? 64'd1 : 64'd0);
    check("bub_hilo", hilo_o, ACC ? 64'h1_0000_0002 : 64'd0);
    // MADD second cycle
    stall = 6'b000000; cnt_i = 2'd2; hilo_i = 64'h5;
    step;
    check("madd2_cnt", {62'd0, cnt_o}, 64'd0);
    check("madd2_hilo", hilo_o, 64'd0);
    check("madd2_wdata", {32'd0, mem_wdata}, 64'hDEAD_BEEF);
    check("madd2_isbubble", {63'd0, mem_isbubble}, 64'd0);
    // hold while ex_* toggles
    ex_wdata = 32'hA5A5_5A5A; ex_wd = 5'd17; cnt_i = 2'd0;
    step;
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      ex_wdata = ~ex_wdata; ex_wd = ex_wd + 5'd1; ex_wreg = ~ex_wreg;
      step;
      check("hold_wdata", {32'd0, mem_wdata}, 64'hA5A5_5A5A);
      check("hold_wd", {59'd0, mem_wd}, 64'd17);
      check("hold_wreg", {63'd0, mem_wreg}, 64'd1);
    end
    // hold keeps an in-flight MADD intermediate
    stall = 6'b001111; cnt_i = 2'd1; hilo_i = 64'hABCD;
    step;
    stall = 6'b011111; cnt_i = 2'd3; hilo_i = 64'h9999;
    step;
    check("hold_cnt", {62'd0, cnt_o}, ACC ? 64'd1 : 64'd0);
    check("hold_hilo", hilo_o, ACC ? 64'hABCD : 64'd0);
    check("hold_isbubble", {63'd0, mem_isbubble}, 64'd1);
    // flush beats bubble
    load_all; stall = 6'b001111; flush = 1; cnt_i = 2'd1; hilo_i = 64'h77;
    step;
    flush = 0;
    check("flush_all", mem_all_or(), 64'd0);
    check("flush_isbubble", {63'd0, mem_isbubble}, 64'd1);
    check("flush_cnt", {62'd0, cnt_o}, 64'd0);
    check("flush_hilo", hilo_o, 64'd0);
    // asynchronous reset mid-cycle after a pass
    stall = 6'b000000; ex_wdata = 32'h1234;
    step;
    check("prerst_wdata", {32'd0, mem_wdata}, 64'h1234);
    #3 rst = 1;
    #1;
    check("arst_all", mem_all_or(), 64'd0);
    check("arst_isbubble", {63'd0, mem_isbubble}, 64'd0);
    step;
    rst = 0;
    // asynchronous reset mid-MADD
    stall = 6'b001111; cnt_i = 2'd1; hilo_i = 64'h1_0000_0002;
    step;
    check("premadd_cnt", {62'd0, cnt_o}, ACC ? 64'd1 : 64'd0);
    #3 rst = 1;
    #1;
    check("arst_cnt", {62'd0, cnt_o}, 64'd0);
    check("arst_hilo", hilo_o, 64'd0);
    check("arst_bub", {63'd0, mem_isbubble}, 64'd0);
    stall = 6'b000000;
    step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
